// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshake, CHUNK bits per stage.
// Define PIPE_ADDER_SAT_EN for signed saturation of D on overflow (default: wrap).
module pipelined_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    input  logic             Sub,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] D,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             OutValid,
    input  logic             OutReady
);
    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned MSB    = WIDTH - 1;

    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bx_q  [STAGES];
    logic [WIDTH-1:0]  bx_d  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  a_src   [STAGES];
    logic [WIDTH-1:0]  bx_src  [STAGES];
    logic [WIDTH-1:0]  sum_src [STAGES];
    logic [STAGES-1:0] cin_src;
    logic [CHUNK:0]    chunk_sum;
    logic              adv;

    assign adv      = !valid_q[STAGES-1] || OutReady;
    assign InReady  = adv;
    assign OutValid = valid_q[STAGES-1];
    assign D        = sum_q[STAGES-1];
    assign CarryOut = carry_q[STAGES-1];
    assign Overflow = ovf_q;

    // Whole operand words travel with each beat; stage k only consumes chunk k,
    // so the untouched upper chunks form the input skew and the filled-in lower
    // chunks of sum form the output deskew.
    always_comb begin
        a_src[0]   = A;
        bx_src[0]  = Sub ? ~B : B;
        cin_src[0] = CarryIn ^ Sub;
        sum_src[0] = '0;
        valid_d[0] = InValid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            bx_src[k]  = bx_q[k-1];
            cin_src[k] = carry_q[k-1];
            sum_src[k] = sum_q[k-1];
            valid_d[k] = valid_q[k-1];
        end

        chunk_sum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            chunk_sum = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                      + {1'b0, bx_src[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, cin_src[k]};
            a_d[k]    = a_src[k];
            bx_d[k]   = bx_src[k];
            sum_d[k]  = sum_src[k];
            sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            carry_d[k] = chunk_sum[CHUNK];
        end

        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        ovf_d = sum_d[STAGES-1][MSB] ^ a_d[STAGES-1][MSB]
              ^ bx_d[STAGES-1][MSB] ^ carry_d[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
        if (ovf_d) begin
            sum_d[STAGES-1] = a_d[STAGES-1][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                sum_q[k] <= '0;
            end
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                bx_q[k]  <= bx_d[k];
                sum_q[k] <= sum_d[k];
            end
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
